// File: rtl/ope_undo.sv
`default_nettype none
// ============================================================================
//  Module   : ope_undo
//  Purpose  : Dual-lane inverse of the ope add-offset stage. Recovers
//             x = y - OFFSET on both lanes, buffers the pairs in a small
//             valid/ready FIFO and compares the lanes on every output
//             transfer, keeping a sticky mismatch flag and a saturating
//             mismatch counter.
//  Revision : 1.0 - initial release
// ============================================================================
module ope_undo #(
   parameter int WIDTH         = 32,
   parameter int OFFSET        = 5,
   parameter int DEPTH         = 4,
   // Enables the lane-equality property; it is expected to fire whenever the
   // encoder lanes are fed different operands, so it is off by default.
   parameter bit LANE_EQ_CHECK = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_y1,
   input  logic [WIDTH-1:0]         in_y2,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_x1,
   output logic [WIDTH-1:0]         out_x2,
   output logic                     mismatch,
   output logic [15:0]              mism_count,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int                c_AW   = $clog2(DEPTH);
   localparam int                c_LW   = c_AW + 1;
   localparam logic [c_LW-1:0]   c_FULL = c_LW'(DEPTH);
   localparam logic [c_LW-1:0]   c_ONE  = c_LW'(1);
   localparam logic [WIDTH-1:0]  c_OFF  = WIDTH'(OFFSET);
   localparam logic [15:0]       c_SAT  = 16'hFFFF;

   logic [WIDTH-1:0]  r_mem1 [DEPTH];
   logic [WIDTH-1:0]  r_mem2 [DEPTH];
   logic [c_AW-1:0]   r_wr;
   logic [c_AW-1:0]   r_rd;
   logic [c_LW-1:0]   r_level;
   logic              r_mismatch;
   logic [15:0]       r_mism_count;

   logic              w_push;
   logic              w_pop;
   logic              w_lane_diff;

   // Handshake qualifiers and head-of-queue lane comparison
   always_comb begin
      in_ready    = rst_n && (r_level != c_FULL);
      out_valid   = (r_level != '0);
      w_push      = in_valid && in_ready;
      w_pop       = out_valid && out_ready;
      out_x1      = r_mem1[r_rd];
      out_x2      = r_mem2[r_rd];
      w_lane_diff = (out_x1 != out_x2);
      level       = r_level;
      mismatch    = r_mismatch;
      mism_count  = r_mism_count;
   end

   // FIFO storage, pointers, occupancy and compare statistics
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem1[i] <= '0;
            r_mem2[i] <= '0;
         end
         r_wr         <= '0;
         r_rd         <= '0;
         r_level      <= '0;
         r_mismatch   <= 1'b0;
         r_mism_count <= '0;
      end else begin
         if (w_push) begin
            // Modulo-2^WIDTH subtraction: small y values wrap to the top.
            r_mem1[r_wr] <= in_y1 - c_OFF;
            r_mem2[r_wr] <= in_y2 - c_OFF;
            r_wr         <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_ONE;
            2'b01:   r_level <= r_level - c_ONE;
            default: r_level <= r_level;
         endcase
         // Only transferred pairs are compared; pushes never touch this.
         if (w_pop && w_lane_diff) begin
            r_mismatch <= 1'b1;
            if (r_mism_count != c_SAT) begin
               r_mism_count <= r_mism_count + 16'd1;
            end
         end
      end
   end

`ifndef SYNTHESIS
   // Occupancy never exceeds the FIFO depth
   a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
      r_level <= c_FULL);

   // No write is accepted while the FIFO is full
   a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
      !(in_valid && in_ready && r_level == c_FULL));

   generate
      if (LANE_EQ_CHECK) begin : g_lane_eq
         // Both recovered lanes agree whenever a pair is presented
         a_lane_eq: assert property (@(posedge clk) disable iff (!rst_n)
            out_valid |-> (out_x1 == out_x2));
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_ope_undo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ope_undo
//  Purpose  : Self-checking bench for ope_undo against a queue-based
//             reference model of the decode FIFO and lane statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ope_undo;

   localparam int WIDTH  = 32;
   localparam int OFFSET = 5;
   localparam int DEPTH  = 4;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_y1;
   logic [WIDTH-1:0]  in_y2;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_x1;
   logic [WIDTH-1:0]  out_x2;
   logic              mismatch;
   logic [15:0]       mism_count;
   logic [2:0]        level;

   ope_undo #(.WIDTH(WIDTH), .OFFSET(OFFSET), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_y1      (in_y1),
      .in_y2      (in_y2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_x1     (out_x1),
      .out_x2     (out_x2),
      .mismatch   (mismatch),
      .mism_count (mism_count),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] x1;
      logic [WIDTH-1:0] x2;
   } pair_t;

   // Reference model state
   pair_t             q[$];
   bit                m_mis;
   int unsigned       m_cnt;
   bit                m_cleared;

   int                checks;
   int                errors;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("level",      64'(level),      64'(q.size()));
      chk("out_valid",  64'(out_valid),  64'(q.size() != 0));
      chk("in_ready",   64'(in_ready),   64'(rst_n && (q.size() < DEPTH)));
      chk("mismatch",   64'(mismatch),   64'(m_mis));
      chk("mism_count", 64'(mism_count), 64'(m_cnt));
      if (q.size() != 0) begin
         chk("out_x1", 64'(out_x1), 64'(q[0].x1));
         chk("out_x2", 64'(out_x2), 64'(q[0].x2));
      end else if (m_cleared) begin
         chk("out_x1_clr", 64'(out_x1), 64'd0);
         chk("out_x2_clr", 64'(out_x2), 64'd0);
      end
   endtask

   // One clock: apply inputs, advance the model by the spec rules, check.
   task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit r, input bit rs, input bit do_chk);
      bit    push;
      bit    pop;
      pair_t hd;
      pair_t nw;
      in_valid  = v;
      in_y1     = a;
      in_y2     = b;
      out_ready = r;
      rst_n     = rs;
      push = rs && v && (q.size() < DEPTH);
      pop  = rs && r && (q.size() != 0);
      @(posedge clk);
      if (!rs) begin
         q.delete();
         m_mis     = 1'b0;
         m_cnt     = 0;
         m_cleared = 1'b1;
      end else begin
         if (pop) begin
            hd = q.pop_front();
            if (hd.x1 != hd.x2) begin
               m_mis = 1'b1;
               if (m_cnt < 65535) m_cnt++;
            end
         end
         if (push) begin
            nw.x1 = a - WIDTH'(OFFSET);
            nw.x2 = b - WIDTH'(OFFSET);
            q.push_back(nw);
            m_cleared = 1'b0;
         end
      end
      #1;
      if (do_chk) check_all();
   endtask

   initial begin
      logic [WIDTH-1:0] r1;
      logic [WIDTH-1:0] r2;
      checks    = 0;
      errors    = 0;
      m_mis     = 1'b0;
      m_cnt     = 0;
      m_cleared = 1'b1;
      in_valid  = 1'b0;
      in_y1     = '0;
      in_y2     = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;

      // Reset: everything cleared, in_ready low while rst_n low
      step(1, 32'd7, 32'd7, 1, 0, 1);
      step(0, 0, 0, 0, 0, 1);

      // Simple decode: 10 -> 5 on both lanes
      step(1, 32'd10, 32'd10, 0, 1, 1);
      chk("dec_x1", 64'(out_x1), 64'd5);
      chk("dec_x2", 64'(out_x2), 64'd5);
      step(0, 0, 0, 1, 1, 1);
      chk("pop_empty", 64'(level), 64'd0);

      // Wrapped subtraction and mismatch
      step(1, 32'd0, 32'd4, 0, 1, 1);
      chk("wrap_x1", 64'(out_x1), 64'hFFFFFFFB);
      chk("wrap_x2", 64'(out_x2), 64'hFFFFFFFF);
      step(0, 0, 0, 1, 1, 1);
      chk("mis_set", 64'(mismatch), 64'd1);
      chk("mis_cnt1", 64'(mism_count), 64'd1);
      step(1, 32'd20, 32'd20, 0, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      chk("mis_sticky", 64'(mismatch), 64'd1);

      // Fill to full with out_ready low, 5th push refused, then drain
      for (int i = 0; i < 4; i++) step(1, 32'(100 + i), 32'(100 + i), 0, 1, 1);
      chk("full_ready", 64'(in_ready), 64'd0);
      step(1, 32'd555, 32'd555, 0, 1, 1);
      chk("full_level", 64'(level), 64'd4);
      step(1, 32'd556, 32'd556, 1, 1, 1);
      chk("full_popx", 64'(out_x1), 64'd96);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);

      // Steady state at level 2 with simultaneous push/pop
      step(1, 32'd200, 32'd200, 0, 1, 1);
      step(1, 32'd201, 32'd201, 0, 1, 1);
      for (int i = 0; i < 10; i++) step(1, 32'(202 + i), 32'(202 + i), 1, 1, 1);
      chk("steady_lvl", 64'(level), 64'd2);
      chk("steady_x1", 64'(out_x1), 64'd205);

      // Reset mid-operation at level 3 while pushing and popping
      step(1, 32'd300, 32'd300, 0, 1, 1);
      chk("pre_rst_lvl", 64'(level), 64'd3);
      step(1, 32'd301, 32'd302, 1, 0, 1);
      chk("rst_lvl", 64'(level), 64'd0);
      chk("rst_cnt", 64'(mism_count), 64'd0);

      // Randomised traffic, lanes occasionally different
      for (int i = 0; i < 400; i++) begin
         r1 = $urandom;
         r2 = ($urandom_range(0, 3) == 0) ? $urandom : r1;
         if ($urandom_range(0, 7) == 0) r1 = 32'($urandom_range(0, 6));
         step(bit'($urandom_range(0, 1)), r1, r2,
              bit'($urandom_range(0, 1)), ($urandom_range(0, 99) != 0), 1);
      end

      // Counter saturation: stream of mismatching pairs at full throughput
      for (int i = 0; i < 65540; i++) step(1, 32'(i), 32'(i + 1), 1, 1, 0);
      check_all();
      chk("sat_cnt", 64'(mism_count), 64'hFFFF);
      step(1, 32'd9, 32'd8, 1, 1, 1);
      step(1, 32'd9, 32'd8, 1, 1, 1);
      chk("sat_hold", 64'(mism_count), 64'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
